alu_regfile_datapath: RTL and testbench

8-bit execution datapath for the single-cycle CPU: an 8-entry × 8-bit register file (two combinational read ports, one synchronous write port) feeding an ALU whose result writes back into the register file. Operand B is selected from the second read port, its two's complement, or an instruction immediate. The block sits between the control unit (opcode decode) and the register-level write-back path.

---
 rtl/alu_regfile_datapath.sv | 81 ++++++++
 tb/tb_alu_regfile_datapath.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_regfile_datapath.sv
// Execution datapath: an 8-entry register file with two combinational read ports
// and one write port, feeding an ALU whose result is written back to the register file.
module alu_regfile_datapath #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] INADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    input  logic [DATA_WIDTH-1:0] IMMEDIATE,
    input  logic [2:0]            ALUOP,
    input  logic                  COMPLEMENT_FLAG,
    input  logic                  IMMEDIATE_FLAG,
    output logic [DATA_WIDTH-1:0] REGOUT1,
    output logic [DATA_WIDTH-1:0] REGOUT2,
    output logic [DATA_WIDTH-1:0] ALU_RESULT
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    localparam logic [2:0] OP_FORWARD = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_AND     = 3'b010;
    localparam logic [2:0] OP_OR      = 3'b011;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_d;
    logic [NUM_REGS-1:0]                 wr_en;

    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] operand_b;
    logic [DATA_WIDTH-1:0] neg_b;

    assign REGOUT1 = regs_q[OUT1ADDRESS];
    assign REGOUT2 = regs_q[OUT2ADDRESS];

    assign operand_a = REGOUT1;
    // Two's complement wraps, so negating the most negative value returns itself.
    assign neg_b = (~REGOUT2) + DATA_WIDTH'(1);

    always_comb begin
        operand_b = REGOUT2;
        if (IMMEDIATE_FLAG) begin
            operand_b = IMMEDIATE;
        end else if (COMPLEMENT_FLAG) begin
            operand_b = neg_b;
        end
    end

    always_comb begin
        ALU_RESULT = '0;
        case (ALUOP)
            OP_FORWARD: ALU_RESULT = operand_b;
            OP_ADD:     ALU_RESULT = operand_a + operand_b;
            OP_AND:     ALU_RESULT = operand_a & operand_b;
            OP_OR:      ALU_RESULT = operand_a | operand_b;
            default:    ALU_RESULT = '0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_wr
            assign wr_en[gi]  = WRITE && (INADDRESS == ADDR_WIDTH'(gi));
            assign regs_d[gi] = wr_en[gi] ? ALU_RESULT : regs_q[gi];
        end
    endgenerate

    // Clear is asynchronous; since writes are also gated by RESET's level, the
    // first edge seen with RESET high is the first one that can write.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Directed, table-driven bench for alu_regfile_datapath with hand-computed expectations.
module tb_alu_regfile_datapath;
    logic       CLK = 1'b0;
    logic       RESET;
    logic       WRITE;
    logic [2:0] INADDRESS;
    logic [2:0] OUT1ADDRESS;
    logic [2:0] OUT2ADDRESS;
    logic [7:0] IMMEDIATE;
    logic [2:0] ALUOP;
    logic       COMPLEMENT_FLAG;
    logic       IMMEDIATE_FLAG;
    logic [7:0] REGOUT1;
    logic [7:0] REGOUT2;
    logic [7:0] ALU_RESULT;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_regfile_datapath #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .WRITE           (WRITE),
        .INADDRESS       (INADDRESS),
        .OUT1ADDRESS     (OUT1ADDRESS),
        .OUT2ADDRESS     (OUT2ADDRESS),
        .IMMEDIATE       (IMMEDIATE),
        .ALUOP           (ALUOP),
        .COMPLEMENT_FLAG (COMPLEMENT_FLAG),
        .IMMEDIATE_FLAG  (IMMEDIATE_FLAG),
        .REGOUT1         (REGOUT1),
        .REGOUT2         (REGOUT2),
        .ALU_RESULT      (ALU_RESULT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic [7:0] a_val;
        logic [7:0] b_val;
        logic [2:0] op;
        logic       comp;
        logic       immf;
        logic [7:0] imm;
        logic [7:0] exp_res;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%02h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic loadi(input logic [2:0] addr, input logic [7:0] val);
        INADDRESS       = addr;
        IMMEDIATE       = val;
        IMMEDIATE_FLAG  = 1'b1;
        COMPLEMENT_FLAG = 1'b0;
        ALUOP           = 3'b000;
        WRITE           = 1'b1;
        tick();
        WRITE           = 1'b0;
        IMMEDIATE_FLAG  = 1'b0;
    endtask

    task automatic read1(input logic [2:0] addr, output logic [7:0] val);
        OUT1ADDRESS = addr;
        #1;
        val = REGOUT1;
    endtask

    initial begin
        logic [7:0] rd;

        vecs[0]  = '{"add_wrap",      8'hF0, 8'h20, 3'b001, 1'b0, 1'b0, 8'h00, 8'h10};
        vecs[1]  = '{"sub_wrap",      8'hF0, 8'h20, 3'b001, 1'b1, 1'b0, 8'h00, 8'hD0};
        vecs[2]  = '{"sub_equal",     8'h05, 8'h05, 3'b001, 1'b1, 1'b0, 8'h00, 8'h00};
        vecs[3]  = '{"and",           8'hCC, 8'hAA, 3'b010, 1'b0, 1'b0, 8'h00, 8'h88};
        vecs[4]  = '{"or",            8'hCC, 8'hAA, 3'b011, 1'b0, 1'b0, 8'h00, 8'hEE};
        vecs[5]  = '{"rsvd_100",      8'hCC, 8'hAA, 3'b100, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[6]  = '{"rsvd_101",      8'hCC, 8'hAA, 3'b101, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[7]  = '{"rsvd_111",      8'hCC, 8'hAA, 3'b111, 1'b0, 1'b1, 8'h3C, 8'h00};
        vecs[8]  = '{"flag_priority", 8'h11, 8'h22, 3'b000, 1'b1, 1'b1, 8'h07, 8'h07};
        vecs[9]  = '{"neg_0x80",      8'h00, 8'h80, 3'b000, 1'b1, 1'b0, 8'h00, 8'h80};
        vecs[10] = '{"mov",           8'h11, 8'h22, 3'b000, 1'b0, 1'b0, 8'h00, 8'h22};
        vecs[11] = '{"add_imm",       8'h3C, 8'h99, 3'b001, 1'b0, 1'b1, 8'h05, 8'h41};
        vecs[12] = '{"neg_0x01",      8'h00, 8'h01, 3'b000, 1'b1, 1'b0, 8'h00, 8'hFF};

        RESET = 1'b0; WRITE = 1'b0; INADDRESS = 3'd0; OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd7;
        IMMEDIATE = 8'h00; ALUOP = 3'b000; COMPLEMENT_FLAG = 1'b0; IMMEDIATE_FLAG = 1'b0;
        #3;
        chk("reset_regout1", REGOUT1, 8'h00);
        chk("reset_regout2", REGOUT2, 8'h00);
        tick();
        RESET = 1'b1;

        // Fill all registers, then assert reset between edges.
        for (int i = 0; i < 8; i++) loadi(3'(i), 8'h55);
        for (int i = 0; i < 8; i++) begin
            read1(3'(i), rd);
            chk($sformatf("fill_r%0d", i), rd, 8'h55);
        end
        #2;
        RESET = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            read1(3'(i), rd);
            chk($sformatf("async_clear_r%0d", i), rd, 8'h00);
        end
        IMMEDIATE = 8'h3C; IMMEDIATE_FLAG = 1'b1; ALUOP = 3'b000;
        #1;
        chk("loadi_during_reset_alu", ALU_RESULT, 8'h3C);
        INADDRESS = 3'd3; IMMEDIATE = 8'h77; WRITE = 1'b1;
        tick();
        WRITE = 1'b0; IMMEDIATE_FLAG = 1'b0;
        read1(3'd3, rd);
        chk("write_blocked_in_reset_r3", rd, 8'h00);
        #2;
        RESET = 1'b1;
        loadi(3'd3, 8'h66);
        read1(3'd3, rd);
        chk("first_write_after_release", rd, 8'h66);

        // loadi then mov.
        loadi(3'd2, 8'h2A);
        read1(3'd2, rd);
        chk("loadi_r2", rd, 8'h2A);
        OUT2ADDRESS = 3'd2; INADDRESS = 3'd5; ALUOP = 3'b000; WRITE = 1'b1;
        tick();
        WRITE = 1'b0;
        read1(3'd5, rd);
        chk("mov_r5", rd, 8'h2A);

        // Write disabled edge.
        IMMEDIATE = 8'h99; IMMEDIATE_FLAG = 1'b1; INADDRESS = 3'd5; WRITE = 1'b0;
        tick();
        IMMEDIATE_FLAG = 1'b0;
        read1(3'd5, rd);
        chk("write_disabled_r5", rd, 8'h2A);

        // No bypass: destination reads old value until the edge.
        loadi(3'd6, 8'h11);
        OUT1ADDRESS = 3'd6; INADDRESS = 3'd6; IMMEDIATE = 8'h44; IMMEDIATE_FLAG = 1'b1;
        ALUOP = 3'b000; WRITE = 1'b1;
        #1;
        chk("no_bypass_before_edge", REGOUT1, 8'h11);
        tick();
        WRITE = 1'b0; IMMEDIATE_FLAG = 1'b0;
        chk("no_bypass_after_edge", REGOUT1, 8'h44);

        // Self-referencing add updates exactly once per edge.
        loadi(3'd1, 8'h30);
        OUT1ADDRESS = 3'd1; OUT2ADDRESS = 3'd1; INADDRESS = 3'd1; ALUOP = 3'b001; WRITE = 1'b1;
        #1;
        chk("selfref_alu_before", ALU_RESULT, 8'h60);
        tick();
        WRITE = 1'b0;
        chk("selfref_r1_after", REGOUT1, 8'h60);
        chk("selfref_alu_after", ALU_RESULT, 8'hC0);

        // Table-driven ALU / operand-B vectors with r1 = A, r2 = B.
        for (int i = 0; i < 13; i++) begin
            loadi(3'd1, vecs[i].a_val);
            loadi(3'd2, vecs[i].b_val);
            OUT1ADDRESS     = 3'd1;
            OUT2ADDRESS     = 3'd2;
            ALUOP           = vecs[i].op;
            COMPLEMENT_FLAG = vecs[i].comp;
            IMMEDIATE_FLAG  = vecs[i].immf;
            IMMEDIATE       = vecs[i].imm;
            WRITE           = 1'b0;
            #1;
            chk({"vec_", vecs[i].name}, ALU_RESULT, vecs[i].exp_res);
            chk({"vec_", vecs[i].name, "_regout2"}, REGOUT2, vecs[i].b_val);
        end

        // Write the sub result back and confirm.
        loadi(3'd1, 8'hF0);
        loadi(3'd2, 8'h20);
        OUT1ADDRESS = 3'd1; OUT2ADDRESS = 3'd2; ALUOP = 3'b001; COMPLEMENT_FLAG = 1'b1;
        INADDRESS = 3'd7; WRITE = 1'b1;
        tick();
        WRITE = 1'b0; COMPLEMENT_FLAG = 1'b0;
        read1(3'd7, rd);
        chk("sub_writeback_r7", rd, 8'hD0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
